// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared opcodes, state encodings, mux/ALU select codes and the
//            control-word type for the multicycle MIPS main control.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [1:0] c_ALUB_B     = 2'b00;
    localparam logic [1:0] c_ALUB_FOUR  = 2'b01;
    localparam logic [1:0] c_ALUB_IMM   = 2'b10;
    localparam logic [1:0] c_ALUB_SHIMM = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Encodings are fixed because `state` is exported for debug.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    // States that stall on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mips_wait_timer
// Purpose  : 8-bit memory wait counter; pulses mem_timeout when a wait reaches
//            limit cycles without completion. limit = 0 never times out.
// Revision : 1.0 - initial release
// ============================================================================
module mips_wait_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       mem_timeout
);

    logic [7:0] r_count;

    assign mem_timeout = enable && (limit != 8'd0) && (r_count == (limit - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (clear || mem_timeout) begin
            r_count <= 8'd0;
        end else if (enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_main_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_main_control
// Purpose  : Moore control FSM for the multicycle MIPS datapath with optional
//            memory wait timeout. Define MIPS_ADDI_EN to build ADDI support.
// Revision : 1.0 - initial release
// ============================================================================
module mips_main_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;
    logic   w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    generate
        if (WAIT_LIMIT != 0) begin : g_timer
            logic w_waiting;
            assign w_waiting = is_wait_state(r_state);

            mips_wait_timer u_wait_timer (
                .clk         (clk),
                .rst         (rst),
                .clear       (!w_waiting || mem_ready),
                .enable      (w_waiting && !mem_ready),
                .limit       (8'(WAIT_LIMIT)),
                .mem_timeout (w_timeout)
            );
        end else begin : g_no_timer
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.alu_src_b = c_ALUB_FOUR;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
                // A timeout here simply restarts the fetch.
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = c_ALUB_SHIMM;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
`ifdef MIPS_ADDI_EN
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
`endif
                    default: begin
                        w_ctrl.illegal_op = 1'b1;
                        w_next            = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_ALUB_IMM;
                w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEMWR: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (mem_ready || w_timeout) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = c_ALUOP_FUNCT;
                w_next           = S_ALUWB;
            end
            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_next           = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = c_ALUOP_SUB;
                w_ctrl.pc_src    = c_PCSRC_ALUOUT;
                w_ctrl.branch    = 1'b1;
                w_next           = S_FETCH;
            end
`ifdef MIPS_ADDI_EN
            S_ADDIEXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_ALUB_IMM;
                w_next           = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
                w_next           = S_FETCH;
            end
`endif
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = c_PCSRC_JUMP;
                w_next          = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks the decode immediately so no write-enable survives it.
    assign w_out = rst ? '0 : w_ctrl;

    assign mem_req     = w_out.mem_req;
    assign mem_write   = w_out.mem_write;
    assign iord        = w_out.iord;
    assign ir_write    = w_out.ir_write;
    assign pc_write    = w_out.pc_write;
    assign branch      = w_out.branch;
    assign reg_dst     = w_out.reg_dst;
    assign mem_to_reg  = w_out.mem_to_reg;
    assign reg_write   = w_out.reg_write;
    assign alu_src_a   = w_out.alu_src_a;
    assign alu_src_b   = w_out.alu_src_b;
    assign alu_op      = w_out.alu_op;
    assign pc_src      = w_out.pc_src;
    assign illegal_op  = w_out.illegal_op;
    assign mem_timeout = w_timeout && !rst;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_main_control
// Purpose  : Randomized self-checking bench; one unlimited-wait and one
//            WAIT_LIMIT=4 instance checked against an instruction-route model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_main_control;

    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_RT   = 6'b000000;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_J    = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode    [2];
    logic        mem_ready [2];
    logic [21:0] obs       [2];

    int total = 0;
    int bad   = 0;

    int          lim  [2] = '{0, 4};
    int          cur  [2];
    int          cnt  [2];
    logic [15:0] route[2];
    int          rlen [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic       mem_req, mem_write, iord, ir_write, pc_write, branch;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic       illegal_op, mem_timeout;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic [3:0] state;

        mips_main_control #(.WAIT_LIMIT(k == 0 ? 0 : 4)) u_dut (
            .clk(clk), .rst(rst), .opcode(opcode[k]), .mem_ready(mem_ready[k]),
            .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
            .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
            .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
            .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
            .pc_src(pc_src), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
            .state(state)
        );

        assign obs[k] = {state, mem_req, mem_write, iord, ir_write, pc_write,
                         branch, reg_dst, mem_to_reg, reg_write, alu_src_a,
                         alu_src_b, alu_op, pc_src, illegal_op, mem_timeout};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        bit ok;
        ok = (op == c_LW) || (op == c_SW) || (op == c_RT) || (op == c_BEQ) || (op == c_J);
`ifdef MIPS_ADDI_EN
        ok = ok || (op == c_ADDI);
`endif
        return ok;
    endfunction

    // States visited after DECODE, low nibble first.
    task automatic plan(input logic [5:0] op, output logic [15:0] r, output int n);
        r = 16'h0;
        n = 0;
        if (op == c_LW)       begin r = 16'h0432; n = 3; end
        else if (op == c_SW)  begin r = 16'h0052; n = 2; end
        else if (op == c_RT)  begin r = 16'h0076; n = 2; end
        else if (op == c_BEQ) begin r = 16'h0008; n = 1; end
        else if (op == c_J)   begin r = 16'h000B; n = 1; end
`ifdef MIPS_ADDI_EN
        else if (op == c_ADDI) begin r = 16'h00A9; n = 2; end
`endif
    endtask

    function automatic logic [21:0] expect_vec(input int st, input logic mr,
                                               input logic [5:0] op, input logic to);
        logic mreq, mwr, io, irw, pcw, br, rdst, m2r, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {mreq, mwr, io, irw, pcw, br, rdst, m2r, rw, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (st)
            0:  begin mreq = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; ill = !legal(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; mwr = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; end
            11: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {4'(st), mreq, mwr, io, irw, pcw, br, rdst, m2r, rw, asa,
                asb, aop, psrc, ill, to};
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 9))
            0: return c_LW;
            1: return c_SW;
            2: return c_RT;
            3: return c_BEQ;
            4: return c_ADDI;
            5: return c_J;
            6: return 6'h3F;
            default: return 6'($urandom());
        endcase
    endfunction

    task automatic advance(input int k);
        if (cur[k] == 0) begin
            cur[k] = 1;
        end else begin
            if (cur[k] == 1) plan(opcode[k], route[k], rlen[k]);
            if (rlen[k] > 0) begin
                cur[k]   = int'(route[k][3:0]);
                route[k] = route[k] >> 4;
                rlen[k]--;
            end else begin
                cur[k] = 0;
            end
        end
        cnt[k] = 0;
    endtask

    task automatic step_and_check(input int k);
        bit   waiting;
        logic to;
        waiting = (cur[k] == 0) || (cur[k] == 3) || (cur[k] == 5);
        to = waiting && !mem_ready[k] && (lim[k] > 0) && (cnt[k] == lim[k] - 1);
        check($sformatf("dut%0d st%0d", k, cur[k]), 32'(obs[k]),
              32'(expect_vec(cur[k], mem_ready[k], opcode[k], to)));
        if (waiting && !mem_ready[k]) begin
            if (to) begin
                cur[k] = 0; cnt[k] = 0; rlen[k] = 0;
            end else begin
                cnt[k]++;
            end
        end else begin
            advance(k);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cur[k] = 0; cnt[k] = 0; rlen[k] = 0; route[k] = 16'h0;
        end
    endtask

    initial begin
        bit pulse;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            opcode[k]    = c_LW;
            mem_ready[k] = 1'b1;
        end
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("reset dut%0d", k), 32'(obs[k]), 32'd0);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (cur[k] == 0) opcode[k] = pick_op();
                mem_ready[k] = ($urandom_range(0, 99) < 60);
            end
            pulse = ($urandom_range(0, 499) == 0) ||
                    ((cur[1] == 4) && ($urandom_range(0, 9) == 0));
            if (pulse) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < 2; k++)
                    check($sformatf("midreset dut%0d", k), 32'(obs[k]), 32'd0);
                model_reset();
            end else begin
                #1;
                for (int k = 0; k < 2; k++) step_and_check(k);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_main_control.md
# mips_main_control

Moore control FSM for the multicycle MIPS datapath. Decodes the instruction-register opcode and steps through fetch/decode/execute/memory/writeback states. Drives the write-enables (`ir_write`, `pc_write`, `reg_write`, …) that feed the `load` inputs of the datapath `Register` instances (IR, PC), plus the mux selects and ALU-op codes. Memory states wait on a `mem_ready` handshake, with an optional timeout.

## Interface
- `WAIT_LIMIT`, default 0: max cycles spent waiting in a memory state. 0 = unlimited; legal range 0..255.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  access is a write.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  IR load.
- `pc_write`  out  1  unconditional PC load.
- `branch`  out  1  PC load if ALU zero.
- `reg_dst`  out  1  register-file destination: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  1  ALU A: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct decode.
- `pc_src`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse: unknown opcode seen in DECODE.
- `mem_timeout`  out  1  one-cycle pulse: wait limit reached.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes:
  - LW = 100011
  - SW = 101011
  - RTYPE = 000000
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Every output not listed for a state is 0.
- Outputs per state:
  - FETCH: `mem_req`=1, `alu_src_b`=01; `ir_write` = `pc_write` = `mem_ready`.
  - DECODE: `alu_src_b`=11.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1.
  - MEMWR: `mem_req`=1, `mem_write`=1, `iord`=1.
  - EXECUTE: `alu_src_a`=1, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1.
  - ADDIEXEC: `alu_src_a`=1, `alu_src_b`=10.
  - ADDIWB: `reg_write`=1.
  - JUMP: `pc_write`=1, `pc_src`=10.
- Transitions:
  - FETCH → DECODE on `mem_ready`; otherwise hold.
  - DECODE → MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEXEC (ADDI), JUMP (J).
  - DECODE → FETCH for any other opcode, with `illegal_op`=1 during the DECODE cycle.
  - MEMADR → MEMRD (LW) or MEMWR (SW).
  - MEMRD → MEMWB on `mem_ready`; MEMWR → FETCH on `mem_ready`.
  - EXECUTE → ALUWB; ADDIEXEC → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMRD or MEMWR, and on `mem_ready`.
  - Increments each cycle spent waiting.
  - With `WAIT_LIMIT`>0, a count of `WAIT_LIMIT`−1 without `mem_ready` pulses `mem_timeout`.
  - On timeout, MEMRD/MEMWR go to FETCH; FETCH re-enters FETCH with the counter cleared.
  - `mem_ready` in the same cycle as the limit: `mem_ready` wins, no timeout.

## Timing
- State register and counter update on rising `clk`. Outputs are combinational from the state, plus `mem_ready` gating in FETCH.
- While `rst`=1: state = FETCH (`state`=0), counter = 0, and every output forced to 0.
- First `mem_req` appears in the first cycle after `rst` deasserts.
- Cycle counts with zero-wait memory (`mem_ready` held high):
  - LW: 5
  - SW: 4
  - RTYPE: 4
  - ADDI: 4
  - BEQ: 3
  - J: 3
  - illegal opcode: 2
- Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- `rst` asserted mid-instruction: immediate return to FETCH; any partial write-enable is dropped within that same cycle.

## Configuration
- `MIPS_ADDI_EN` defined: ADDI decodes to ADDIEXEC → ADDIWB.
- `MIPS_ADDI_EN` undefined:
  - ADDIEXEC and ADDIWB are not built.
  - Opcode 001000 is illegal: `illegal_op` pulses and the FSM returns to FETCH.
  - Encodings 9 and 10 are unused; any unused encoding → FETCH.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - the state enum with the fixed 4-bit encodings above;
  - `alu_src_b`, `alu_op` and `pc_src` encoding constants.
- Optional sub-module `mips_wait_timer`: 8-bit wait counter with inputs clear, enable and limit, and the `mem_timeout` output.

## Test plan
- Reset, then release with `mem_ready`=1 and `opcode`=100011 (LW):
  - states 0,1,2,3,4,0;
  - `ir_write`=1 only in cycle 1;
  - `reg_write`=`mem_to_reg`=1 only in state 4.
- SW with `mem_ready` low for 3 cycles in MEMWR:
  - `state` holds 5 for 4 cycles with `mem_write`=1;
  - returns to 0;
  - `reg_write` never asserted.
- BEQ, then J, then RTYPE:
  - BEQ: `branch`=1, `pc_src`=01 in state 8;
  - J: `pc_write`=1, `pc_src`=10 in state 11;
  - RTYPE: `reg_dst`=1 in state 7.
- `opcode`=111111: `illegal_op` pulses once in state 1, next state 0, no write-enables asserted.
- `WAIT_LIMIT`=4, `mem_ready` held 0 in MEMRD:
  - `mem_timeout` pulses on the 4th wait cycle;
  - next state 0.
  - Repeat with `mem_ready`=1 on the 4th cycle: no timeout, next state 4.
- `rst` pulsed while in MEMWB: `reg_write` drops in the same cycle and `state`=0.
- With `MIPS_ADDI_EN` undefined, opcode 001000: `illegal_op`=1 and the FSM returns to FETCH.
